// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and helpers for the sequential radix-4 Booth multiplier
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_ZERO,
        OP_P1,
        OP_P2,
        OP_M1,
        OP_M2
    } booth_op_t;

    // Triplet is {x[2i+1], x[2i], x[2i-1]}
    function automatic booth_op_t booth_decode(input logic [2:0] triplet);
        booth_op_t op;
        case (triplet)
            3'b001, 3'b010: op = OP_P1;
            3'b011:         op = OP_P2;
            3'b100:         op = OP_M2;
            3'b101, 3'b110: op = OP_M1;
            default:        op = OP_ZERO;
        endcase
        return op;
    endfunction

    function automatic int calc_iter(input int n);
        return n / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// rtl/booth_r4_encoder.sv - radix-4 Booth digit to signed partial product
module booth_r4_encoder
    import mult_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [2:0]          triplet,
    input  logic [N+1:0]        a_ext,
    output logic signed [N+2:0] pp
);

    logic signed [N+2:0] a_s;

    assign a_s = $signed({a_ext[N+1], a_ext});

    always_comb begin
        pp = '0;
        case (booth_decode(triplet))
            OP_P1:   pp = a_s;
            OP_P2:   pp = a_s <<< 1;
            OP_M1:   pp = -a_s;
            OP_M2:   pp = -(a_s <<< 1);
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/seq_booth_multiplier.sv
// rtl/seq_booth_multiplier.sv - multi-cycle radix-4 Booth multiplier with valid/ready channels
module seq_booth_multiplier
    import mult_pkg::*;
#(
    parameter int N = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   x,
    input  logic           is_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] P
);

    localparam int ITER = calc_iter(N);
    localparam int XW   = N + 2;
    localparam int CW   = $clog2(ITER + 1);

    if ((N < 4) || (N % 2 != 0)) begin : g_bad_n
        $error("seq_booth_multiplier: N must be even and >= 4");
    end

    state_t         state_q, state_d;
    logic [XW-1:0]  a_q, a_d;
    logic [XW-1:0]  hi_q, hi_d;
    logic [XW-1:0]  lo_q, lo_d;
    logic           xm1_q, xm1_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [XW-1:0]        a_ext, x_ext;
    logic signed [XW:0]   pp;
    logic signed [XW+1:0] sum;

    assign a_ext = {{2{is_signed & a[N-1]}}, a};
    assign x_ext = {{2{is_signed & x[N-1]}}, x};

    booth_r4_encoder #(.N(N)) u_enc (
        .triplet ({lo_q[1:0], xm1_q}),
        .a_ext   (a_q),
        .pp      (pp)
    );

    // Product register is {hi, lo}: lo starts as the multiplier and is consumed
    // two bits per step while the running sum shifts in from hi.
    assign sum = $signed({{2{hi_q[XW-1]}}, hi_q}) + $signed({pp[XW], pp});

    assign P = {hi_q[XW-5:0], lo_q};

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        xm1_d     = xm1_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a_ext;
                    hi_d    = '0;
                    lo_d    = x_ext;
                    xm1_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                hi_d  = sum[XW+1:2];
                lo_d  = {sum[1:0], lo_q[XW-1:2]};
                xm1_d = lo_q[1];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            xm1_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            xm1_q   <= xm1_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// tb/tb_seq_booth_multiplier.sv - self-checking bench for seq_booth_multiplier (N=64)
module tb_seq_booth_multiplier;

    localparam int N    = 64;
    localparam int ITER = N / 2 + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N-1:0]   a = '0;
    logic [N-1:0]   x = '0;
    logic           is_signed = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*N-1:0] P;

    int total = 0;
    int bad   = 0;

    seq_booth_multiplier #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .x         (x),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (P)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] model_mul(input logic [N-1:0] ma, input logic [N-1:0] mx,
                                               input logic ms);
        logic [127:0] ea, ex;
        ea = ms ? {{64{ma[N-1]}}, ma} : {64'b0, ma};
        ex = ms ? {{64{mx[N-1]}}, mx} : {64'b0, mx};
        return ea * ex;
    endfunction

    // Reference model: phase 0 idle, 1 computing, 2 holding a result
    int           m_phase = 0;
    int           m_left  = 0;
    bit           m_armed = 1'b0;
    logic [127:0] m_exp   = '0;

    always @(negedge clk) begin
        if (m_armed) begin
            check("mon_in_ready", {127'b0, in_ready}, {127'b0, m_phase == 0});
            check("mon_out_valid", {127'b0, out_valid}, {127'b0, m_phase == 2});
            if (m_phase == 2) check("mon_P", P, m_exp);
        end
        if (rst) begin
            m_phase = 0;
            m_armed = 1'b1;
        end else if (m_armed) begin
            case (m_phase)
                0: if (in_valid) begin
                    m_exp   = model_mul(a, x, is_signed);
                    m_left  = ITER;
                    m_phase = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [N-1:0] ta, input logic [N-1:0] tx, input logic ts);
        int w;
        a = ta; x = tx; is_signed = ts; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin tick(); w++; end
        if (!in_ready) check("accept_timeout", 128'd0, 128'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input logic [127:0] exp, input bit churn);
        int lat;
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (churn) begin
                a = {$urandom, $urandom}; x = {$urandom, $urandom}; is_signed = $urandom_range(0, 1);
            end
            tick();
            lat++;
        end
        check({name, "_latency"}, 128'(lat), 128'(ITER));
        check(name, P, exp);
    endtask

    task automatic pop();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [N-1:0] ta, input logic [N-1:0] tx,
                          input logic ts, input logic [127:0] exp);
        start_op(ta, tx, ts);
        wait_done(name, exp, 1'b0);
        pop();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        tick();
        tick();
        check("rst_in_ready", {127'b0, in_ready}, 128'd1);
        check("rst_out_valid", {127'b0, out_valid}, 128'd0);
        check("rst_P", P, 128'd0);
        rst = 1'b0;
        tick();

        run_op("s_10x85", 64'd10, 64'd85, 1'b1, 128'd850);
        run_op("s_m10xm25", -64'sd10, -64'sd25, 1'b1, 128'd250);
        run_op("s_10xm5", 64'd10, -64'sd5, 1'b1, -128'sd50);

        run_op("u_maxx2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0,
               128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFE);
        run_op("s_m1x2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1,
               128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE);

        run_op("s_min_sq", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
               128'h4000_0000_0000_0000_0000_0000_0000_0000);
        run_op("u_max_sq", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
               128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        run_op("s_m125x6789", -64'sd125, 64'd6789, 1'b1, -128'sd848625);
        run_op("u_zero", 64'd0, 64'd0, 1'b0, 128'd0);

        // Backpressure: result must hold while new operands are offered and ignored
        start_op(64'd7, 64'd9, 1'b0);
        wait_done("bp_first", 128'd63, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            a = 64'd1234 + 64'(i); x = 64'd99;
            tick();
            check("bp_hold_P", P, 128'd63);
            check("bp_hold_valid", {127'b0, out_valid}, 128'd1);
            check("bp_hold_in_ready", {127'b0, in_ready}, 128'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_pop_valid", {127'b0, out_valid}, 128'd0);
        check("bp_pop_in_ready_late", {127'b0, in_ready}, 128'd1);

        // Reset during computation discards the in-flight result
        start_op(64'd5678, 64'd1234, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_in_ready", {127'b0, in_ready}, 128'd1);
        check("mid_rst_out_valid", {127'b0, out_valid}, 128'd0);
        check("mid_rst_P", P, 128'd0);
        run_op("after_rst", 64'd235, 64'd62589, 1'b0, 128'd14708415);

        // Inputs churn while busy; result reflects the accepted operands only
        start_op(64'd100, 64'd5, 1'b1);
        wait_done("churn", 128'd500, 1'b1);
        a = '0; x = '0; is_signed = 1'b0;
        pop();
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
